// File: rtl/ce_acc.sv
// Convolution-engine accumulator: dot product of one beat, summed over PASSES beats, then shift/ReLU/saturate.
// Optional macro CE_ACC_ROUND_EN selects round-half-up before the shift (default: floor truncation).
module ce_acc #(
  parameter int CL_IN  = 1,
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int PASSES = 2,
  parameter int SR     = 2,
  parameter int RELU   = 1,
  parameter int OW     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CL_IN*KERNEL*KERNEL*N-1:0]    data2conv,
  input  logic [CL_IN*KERNEL*KERNEL*M-1:0]    w,
  input  logic                                en_in,
  output logic                                in_rdy,
  output logic [OW-1:0]                       d_out,
  output logic                                en_out,
  input  logic                                out_rdy
);

  localparam int K2    = KERNEL * KERNEL;
  localparam int E     = CL_IN * K2;
  localparam int NM    = N + M;
  localparam int PW    = N + M + $clog2(E);
  localparam int ACC_W = PW + $clog2(PASSES) + 1;
  localparam int CW    = $clog2(PASSES + 1);
  localparam int SW    = (ACC_W + 1 > OW + 1) ? ACC_W + 1 : OW + 1;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(64'sd1 <<< (OW - 1)));
`ifdef CE_ACC_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'((64'sd1 <<< SR) >>> 1);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  logic [E*N-1:0]          data_q;
  logic [E*M-1:0]          w_q;
  logic                    v0_q, first0_q, last0_q;
  logic signed [PW-1:0]    psum_q, psum_d;
  logic                    v1_q, first1_q, last1_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CW-1:0]           cnt_in_q, cnt_in_d;
  logic [OW-1:0]           d_out_q, d_out_d;
  logic                    en_out_q, en_out_d;
  logic [OW-1:0]           post_w;
  logic [1:0]              state;
  logic                    accept, out_fire, last_beat;
  logic signed [NM-1:0]    prod_w [E];

  // Operands are widened before multiplying so the full N+M-bit product is kept.
  generate
    for (genvar gi = 0; gi < E; gi++) begin : g_prod
      assign prod_w[gi] = NM'($signed(data_q[gi*N +: N])) * NM'($signed(w_q[gi*M +: M]));
    end
  endgenerate

  always_comb begin
    psum_d = '0;
    for (int e = 0; e < E; e++) begin
      psum_d = psum_d + PW'(prod_w[e]);
    end
  end

  always_comb begin
    if (en_out_q)                     state = ST_HOLD;
    else if (cnt_in_q == CW'(PASSES)) state = ST_DRAIN;
    else                              state = ST_ACC;
  end

  assign in_rdy    = (state == ST_ACC);
  assign accept    = en_in & in_rdy;
  assign out_fire  = en_out_q & out_rdy;
  assign last_beat = (cnt_in_q == CW'(PASSES - 1));

  assign acc_sum = (first1_q ? '0 : acc_q) + ACC_W'(psum_q);
  assign acc_d   = v1_q ? acc_sum : acc_q;

  // Shift first (optionally rounded), then ReLU, then clamp into the output range.
  always_comb begin
    logic signed [SW-1:0] x;
    x = SW'(acc_sum) + RND;
    x = x >>> SR;
    if (RELU != 0 && x < 0) x = '0;
    if (x > SAT_MAX)      x = SAT_MAX;
    else if (x < SAT_MIN) x = SAT_MIN;
    post_w = OW'(x);
  end

  always_comb begin
    d_out_d  = d_out_q;
    en_out_d = en_out_q;
    if (out_fire) en_out_d = 1'b0;
    if (v1_q && last1_q) begin
      d_out_d  = post_w;
      en_out_d = 1'b1;
    end
  end

  always_comb begin
    cnt_in_d = cnt_in_q;
    if (out_fire)    cnt_in_d = '0;
    else if (accept) cnt_in_d = cnt_in_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      w_q      <= '0;
      v0_q     <= 1'b0;
      first0_q <= 1'b0;
      last0_q  <= 1'b0;
      psum_q   <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      acc_q    <= '0;
      cnt_in_q <= '0;
      d_out_q  <= '0;
      en_out_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= data2conv;
        w_q    <= w;
      end
      v0_q     <= accept;
      first0_q <= accept && (cnt_in_q == '0);
      last0_q  <= accept && last_beat;
      psum_q   <= v0_q ? psum_d : psum_q;
      v1_q     <= v0_q;
      first1_q <= first0_q;
      last1_q  <= last0_q;
      acc_q    <= acc_d;
      cnt_in_q <= cnt_in_d;
      d_out_q  <= d_out_d;
      en_out_q <= en_out_d;
    end
  end

  assign d_out  = d_out_q;
  assign en_out = en_out_q;

endmodule

// File: tb/tb_ce_acc.sv
// Bench for ce_acc: two instances (RELU=1 and RELU=0) share stimulus; expected results go through queues.
module tb_ce_acc;

  localparam int EL = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [EL*4-1:0] data2conv = '0;
  logic [EL*4-1:0] w = '0;
  logic          en_in = 1'b0;
  logic          out_rdy = 1'b1;
  logic          in_rdy, in_rdy_l;
  logic [7:0]    d_out, d_out_l;
  logic          en_out, en_out_l;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_r_q[$];
  int exp_l_q[$];

  always #5 clk = ~clk;

  ce_acc #(.CL_IN(1), .KERNEL(3), .N(4), .M(4), .PASSES(2), .SR(2), .RELU(1), .OW(8)) u_dut (
    .clk(clk), .rst(rst), .data2conv(data2conv), .w(w), .en_in(en_in), .in_rdy(in_rdy),
    .d_out(d_out), .en_out(en_out), .out_rdy(out_rdy));

  ce_acc #(.CL_IN(1), .KERNEL(3), .N(4), .M(4), .PASSES(2), .SR(2), .RELU(0), .OW(8)) u_lin (
    .clk(clk), .rst(rst), .data2conv(data2conv), .w(w), .en_in(en_in), .in_rdy(in_rdy_l),
    .d_out(d_out_l), .en_out(en_out_l), .out_rdy(out_rdy));

  function automatic logic [EL*4-1:0] splat(input int v);
    logic [EL*4-1:0] r;
    for (int e = 0; e < EL; e++) r[e*4 +: 4] = 4'(v);
    return r;
  endfunction

  // Reference post-processing: floor division by 4 done with / and %, not shifts.
  function automatic int model(input longint acc, input bit relu);
    longint v, q;
    v = acc;
`ifdef CE_ACC_ROUND_EN
    v = v + 2;
`endif
    q = v / 4;
    if ((v % 4) != 0 && v < 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic beat(input logic [EL*4-1:0] d, input logic [EL*4-1:0] ww);
    int t;
    data2conv = d;
    w = ww;
    en_in = 1'b1;
    t = 0;
    while (!in_rdy && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_rdy) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept: in_rdy=%0b after %0d cycles, required 1", in_rdy, t);
    end
    @(posedge clk); #1;
    en_in = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int t, er, el;
    t = 0;
    while (!en_out && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (!en_out || exp_r_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: en_out=%0b queued=%0d, required en_out=1", name, en_out, exp_r_q.size());
      return;
    end
    er = exp_r_q.pop_front();
    el = exp_l_q.pop_front();
    if (int'($signed(d_out)) !== er) begin
      n_fail++;
      $display("FAIL %s_relu: d_out=%0d required %0d", name, $signed(d_out), er);
    end
    n_checks++;
    if (!en_out_l || int'($signed(d_out_l)) !== el) begin
      n_fail++;
      $display("FAIL %s_lin: d_out=%0d en_out=%0b required %0d", name, $signed(d_out_l), en_out_l, el);
    end
    $display("%s: d_out relu=%0d lin=%0d", name, $signed(d_out), $signed(d_out_l));
    if (out_rdy) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic group_const(input int dv, input int wv, input int gap, input int er, input int el);
    for (int p = 0; p < 2; p++) begin
      beat(splat(dv), splat(wv));
      for (int g = 0; g < gap && p == 0; g++) begin
        @(posedge clk); #1;
      end
    end
    exp_r_q.push_back(er);
    exp_l_q.push_back(el);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (d_out !== 8'd0 || en_out !== 1'b0 || in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: d_out=%0d en_out=%0b in_rdy=%0b required 0/0/1", d_out, en_out, in_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("test_reset: d_out=%0d en_out=%0b in_rdy=%0b", d_out, en_out, in_rdy);
  endtask

  task automatic test_basic();
    int r;
`ifdef CE_ACC_ROUND_EN
    r = 5;
`else
    r = 4;
`endif
    beat(splat(1), splat(1));
    beat(splat(1), splat(1));
    exp_r_q.push_back(r);
    exp_l_q.push_back(r);
    n_checks++;
    if (en_out !== 1'b0) begin
      n_fail++; $display("FAIL latency_e0: en_out=%0b required 0", en_out);
    end
    @(posedge clk); #1;
    n_checks++;
    if (en_out !== 1'b0) begin
      n_fail++; $display("FAIL latency_e1: en_out=%0b required 0", en_out);
    end
    @(posedge clk); #1;
    n_checks++;
    if (en_out !== 1'b1 || in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL latency_e2: en_out=%0b in_rdy=%0b required 1/0", en_out, in_rdy);
    end
    wait_result("test_basic");
  endtask

  task automatic test_neg();
`ifdef CE_ACC_ROUND_EN
    group_const(-1, 1, 0, 0, -4);
`else
    group_const(-1, 1, 0, 0, -5);
`endif
    wait_result("test_neg");
  endtask

  task automatic test_sat();
    group_const(7, 7, 0, 127, 127);
    wait_result("test_sat");
    group_const(-8, 7, 1, 0, -128);
    wait_result("test_sat_neg");
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int t, r;
`ifdef CE_ACC_ROUND_EN
    r = 5;
`else
    r = 4;
`endif
    out_rdy = 1'b0;
    group_const(1, 1, 0, r, r);
    t = 0;
    while (!en_out && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    held = d_out;
    for (int i = 0; i < 5; i++) begin
      en_in = i[0] ? 1'b0 : 1'b1;
      data2conv = splat(7);
      w = splat(7);
      @(posedge clk); #1;
      n_checks++;
      if (en_out !== 1'b1 || d_out !== held || in_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: en_out=%0b d_out=%0d in_rdy=%0b required 1/%0d/0", i, en_out, d_out, in_rdy, held);
      end
    end
    en_in = 1'b0;
    out_rdy = 1'b1;
    wait_result("test_backpressure");
    n_checks++;
    if (en_out !== 1'b0 || in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: en_out=%0b in_rdy=%0b required 0/1", en_out, in_rdy);
    end
    group_const(1, 1, 0, r, r);
    wait_result("test_after_bp");
  endtask

  task automatic test_reset_mid();
    int r;
`ifdef CE_ACC_ROUND_EN
    r = 5;
`else
    r = 4;
`endif
    beat(splat(7), splat(7));
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (d_out !== 8'd0 || en_out !== 1'b0 || in_rdy !== 1'b1 || d_out_l !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: d_out=%0d en_out=%0b in_rdy=%0b required 0/0/1", d_out, en_out, in_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    group_const(1, 1, 3, r, r);
    wait_result("test_reset_mid");
  endtask

  task automatic test_random();
    logic [EL*4-1:0] dv, wv;
    longint acc;
    int dn, wn;
    for (int g = 0; g < 6; g++) begin
      acc = 0;
      for (int p = 0; p < 2; p++) begin
        for (int e = 0; e < EL; e++) begin
          dn = int'($urandom_range(0, 15));
          wn = int'($urandom_range(0, 15));
          dv[e*4 +: 4] = 4'(dn);
          wv[e*4 +: 4] = 4'(wn);
          acc = acc + longint'((dn >= 8 ? dn - 16 : dn) * (wn >= 8 ? wn - 16 : wn));
        end
        beat(dv, wv);
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          @(posedge clk); #1;
        end
      end
      exp_r_q.push_back(model(acc, 1'b1));
      exp_l_q.push_back(model(acc, 1'b0));
      wait_result("test_random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg();
    test_sat();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ce_acc.md
CE_ACC -- requirements
Module: ce_acc

Interface
REQ-001 Parameter CL_IN, default 1: input feature channels per beat (1..256).
REQ-002 Parameter KERNEL, default 3: kernel side (1/3/5/7); K2 = KERNEL*KERNEL.
REQ-003 Parameter N, default 4: signed data element width.
REQ-004 Parameter M, default 4: signed weight element width.
REQ-005 Parameter PASSES, default 2: beats accumulated per output (1..64).
REQ-006 Parameter SR, default 2: arithmetic right shift applied before output (0..ACC_W-1).
REQ-007 Parameter RELU, default 1: 1 = negative results forced to 0; 0 = signed output.
REQ-008 Parameter OW, default 8: signed output width.
REQ-009 Derived widths:
- PW = N+M+clog2(CL_IN*K2).
- ACC_W = PW+clog2(PASSES)+1.
REQ-010 clk  in  1  single clock; all state changes on its rising edge.
REQ-011 rst  in  1  asynchronous, active-high reset.
REQ-012 data2conv  in  CL_IN*K2*N  signed data; element e occupies bits [e*N +: N].
REQ-013 w  in  CL_IN*K2*M  signed weights; element e occupies bits [e*M +: M].
REQ-014 en_in  in  1  input beat valid.
REQ-015 in_rdy  out  1  block accepts a beat; a beat is accepted on an edge where en_in and in_rdy are both 1.
REQ-016 d_out  out  OW  result.
REQ-017 en_out  out  1  d_out valid.
REQ-018 out_rdy  in  1  downstream accepts the result; the handshake completes on an edge where en_out and out_rdy are both 1.

Function
REQ-019 Stage 1 registers psum (PW bits, signed) = sum of all CL_IN*K2 signed products data[e]*w[e], one edge after the beat is accepted.
REQ-020 Stage 2 updates the accumulator on the following edge:
- acc = psum for the first beat of a group.
- acc = acc+psum for every later beat of the group.
REQ-021 Counter cnt_in counts accepted beats 0..PASSES; in_rdy = (cnt_in < PASSES) and not en_out.
REQ-022 On the stage-2 edge of beat PASSES, the post-processed value of (acc+psum) is registered into d_out and en_out is set to 1.
REQ-023 Result latency is 2 clock edges after the edge that accepted the last beat.
REQ-024 Post-processing is applied in this order:
- arithmetic shift right by SR, with rounding per REQ-032/033;
- ReLU if RELU=1;
- saturation to the signed OW range [-2^(OW-1), 2^(OW-1)-1].
REQ-025 When out_rdy=0, d_out and en_out hold their values and no new beat is accepted.
REQ-026 On the output-handshake edge:
- en_out clears to 0;
- cnt_in clears to 0;
- in_rdy returns to 1 in the next cycle.
REQ-027 en_in=0 cycles between beats are legal; they leave acc and cnt_in unchanged.
REQ-028 en_in asserted while in_rdy=0 is ignored.
REQ-029 States:
- ACC: cnt_in < PASSES.
- DRAIN: cnt_in = PASSES and en_out = 0.
- HOLD: en_out = 1.
REQ-030 State transitions:
- ACC -> DRAIN on the accept edge of beat PASSES.
- DRAIN -> HOLD on the edge that sets en_out.
- HOLD -> ACC on the output-handshake edge.
REQ-031 PASSES=1 is legal; in that case every accepted beat produces one output.

Configuration
REQ-032 With macro CE_ACC_ROUND_EN defined, 2^(SR-1) is added before the shift (round half up); when SR=0, nothing is added.
REQ-033 Without CE_ACC_ROUND_EN, the shift truncates toward negative infinity.

Reset
REQ-034 While rst=1, the following are held at 0 regardless of clk:
- d_out, en_out, cnt_in, psum, acc and all pipeline valid flags.
- State is ACC, so in_rdy=1 once rst=0.
REQ-035 A reset during accumulation discards any partial group; the next accepted beat starts a new group.

Verification (N=M=4, KERNEL=3, CL_IN=1, PASSES=2, SR=2, OW=8)
REQ-036 All data=1, w=1, two back-to-back beats, RELU=1: acc=18; d_out=4 without the macro, 5 with it; en_out rises 2 edges after the second accept.
REQ-037 All data=-1, w=1, two beats:
- RELU=1: d_out=0.
- RELU=0: d_out=-5 without the macro, -4 with it.
REQ-038 All data=7, w=7, two beats: acc=882, shifted value 220; d_out saturates to 127.
REQ-039 Backpressure, out_rdy=0 for 5 cycles after en_out rises:
- d_out, en_out=1 and in_rdy=0 stay stable;
- en_in pulses during this time are ignored.
- After out_rdy=1: en_out=0 after the next edge, and in_rdy=1.
REQ-040 Reset after one accepted beat: all outputs are 0. Then two beats with data=1, w=1, with 3 idle cycles between them, give d_out=4 (no macro).
